jts16_char_shifter: RTL and testbench

- Pixel serializer downstream of the character-layer tile fetch stage.
- Accepts 16-bit character ROM words (4 pixels, 4 bpp packed) plus tile attributes over a valid/ready load port, and buffers them in a small FIFO.
- Emits one 8-bit pixel {prio, pal[2:0], colour[3:0]} per pxl_cen to the layer mixer/priority stage.
- Detects and counts underruns.

---
 rtl/jts16_char_pkg.sv | 32 +++
 rtl/jts16_char_fifo.sv | 63 ++++++
 rtl/jts16_char_shifter.sv | 148 ++++++++++++++
 tb/tb_jts16_char_shifter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/jts16_char_pkg.sv
// Shared types and helpers for the character-layer pixel serializer.
// The optional horizontal flip is enabled with JTS16_CHAR_HFLIP_EN.
package jts16_char_pkg;

    localparam int PXL_W   = 8;
    localparam int WORD_W  = 16;
    localparam int NIBBLES = 4;

    // One queued character word with its attributes
    typedef struct packed {
        logic        hflip;
        logic        prio;
        logic [2:0]  pal;
        logic [15:0] data;
    } char_entry_t;

    // Pick the colour nibble for a pixel index; flip reverses the order
    function automatic logic [3:0] nibble_sel(input logic [15:0] data,
                                              input logic [1:0]  idx,
                                              input logic        flip);
        logic [1:0] pos;
        pos = flip ? ~idx : idx;
        case (pos)
            2'd0:    return data[15:12];
            2'd1:    return data[11:8];
            2'd2:    return data[7:4];
            2'd3:    return data[3:0];
            default: return 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/jts16_char_fifo.sv
// Small synchronous FIFO with flush. The head entry is visible on dout
// whenever the FIFO is non-empty. DEPTH must be a power of two.
module jts16_char_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 21
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == '0);
    assign push_ok_s = push && !full && !flush;
    assign pop_ok_s  = pop && !empty && !flush;
    assign dout      = mem_r[rd_ptr_r];

    // Pointer and occupancy tracking; pointers wrap naturally modulo DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/jts16_char_shifter.sv
// Character-layer pixel serializer: queues 4-pixel ROM words and emits one
// {prio, pal, colour} pixel per pixel-clock enable, counting underruns.
// Define JTS16_CHAR_HFLIP_EN to honour the per-word horizontal flip bit.
module jts16_char_shifter
    import jts16_char_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNTW  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pxl_cen,
    input  logic            line_start,
    input  logic            active,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [15:0]     ld_data,
    input  logic [2:0]      ld_pal,
    input  logic            ld_prio,
    input  logic            ld_hflip,
    output logic [7:0]      pxl,
    output logic            underrun,
    output logic [CNTW-1:0] underrun_cnt,
    input  logic            clr_err
);
`ifdef JTS16_CHAR_HFLIP_EN
    localparam int FIFO_W = 21;
`else
    localparam int FIFO_W = 20;
`endif

    logic [FIFO_W-1:0] push_word_s;
    logic [FIFO_W-1:0] head_word_s;
    char_entry_t       head_s;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic              shift_s;

    char_entry_t       sh_r;
    logic              sh_full_r;
    logic [1:0]        idx_r;
    logic [PXL_W-1:0]  pxl_r;
    logic              underrun_r;
    logic [CNTW-1:0]   cnt_r;

`ifdef JTS16_CHAR_HFLIP_EN
    assign push_word_s = {ld_hflip, ld_prio, ld_pal, ld_data};
    assign head_s      = head_word_s;
`else
    // Flip input is not stored in this build
    logic unused_hflip_s;
    assign unused_hflip_s = ld_hflip;
    assign push_word_s    = {ld_prio, ld_pal, ld_data};
    assign head_s         = {1'b0, head_word_s};
`endif

    // No acceptance in reset, while full, or during a line flush
    assign ld_ready = rst_n && !full_s && !line_start;
    assign push_s   = ld_valid && ld_ready;
    // A visible pixel is being consumed from a loaded shifter
    assign shift_s  = pxl_cen && active && sh_full_r;

    // FIFO head is consumed when the shifter is empty or finishes its last pixel
    always_comb begin
        pop_s = 1'b0;
        if (line_start) begin
            pop_s = 1'b0;
        end else if (!sh_full_r) begin
            pop_s = !empty_s;
        end else if (shift_s && (idx_r == 2'd3)) begin
            pop_s = !empty_s;
        end else begin
            pop_s = 1'b0;
        end
    end

    jts16_char_fifo #(
        .DEPTH (DEPTH),
        .W     (FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (line_start),
        .push  (push_s),
        .pop   (pop_s),
        .din   (push_word_s),
        .dout  (head_word_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Shifter contents and pixel index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_r      <= '0;
            sh_full_r <= 1'b0;
            idx_r     <= 2'd0;
        end else if (line_start) begin
            sh_full_r <= 1'b0;
            idx_r     <= 2'd0;
        end else if (pop_s) begin
            sh_r      <= head_s;
            sh_full_r <= 1'b1;
            idx_r     <= 2'd0;
        end else if (shift_s) begin
            if (idx_r == 2'd3) begin
                sh_full_r <= 1'b0;
                idx_r     <= 2'd0;
            end else begin
                idx_r     <= idx_r + 2'd1;
            end
        end
    end

    // Registered pixel output, updated only on pixel-clock enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pxl_r <= '0;
        end else if (pxl_cen) begin
            if (shift_s && !line_start) begin
                pxl_r <= {sh_r.prio, sh_r.pal, nibble_sel(sh_r.data, idx_r, sh_r.hflip)};
            end else begin
                pxl_r <= '0;
            end
        end
    end

    // Sticky underrun flag and saturating count; clearing wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_r <= 1'b0;
            cnt_r      <= '0;
        end else if (clr_err) begin
            underrun_r <= 1'b0;
            cnt_r      <= '0;
        end else if (pxl_cen && active && !sh_full_r && !line_start) begin
            underrun_r <= 1'b1;
            if (cnt_r != {CNTW{1'b1}}) cnt_r <= cnt_r + CNTW'(1'b1);
        end
    end

    assign pxl          = pxl_r;
    assign underrun     = underrun_r;
    assign underrun_cnt = cnt_r;

endmodule

// File: tb/tb_jts16_char_shifter.sv
// Directed self-checking bench for the character pixel serializer.
module tb_jts16_char_shifter;

    logic        clk;
    logic        rst_n;
    logic        pxl_cen;
    logic        line_start;
    logic        active;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_data;
    logic [2:0]  ld_pal;
    logic        ld_prio;
    logic        ld_hflip;
    logic [7:0]  pxl;
    logic        underrun;
    logic [7:0]  underrun_cnt;
    logic        clr_err;

    int errors = 0;
    int checks = 0;

    jts16_char_shifter #(.DEPTH(2), .CNTW(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pxl_cen      (pxl_cen),
        .line_start   (line_start),
        .active       (active),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .ld_pal       (ld_pal),
        .ld_prio      (ld_prio),
        .ld_hflip     (ld_hflip),
        .pxl          (pxl),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .clr_err      (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Three idle clocks, then one pixel-clock enable, then check pxl
    task automatic pix(input string tag, input logic [7:0] exp);
        repeat (3) step();
        pxl_cen = 1'b1;
        step();
        pxl_cen = 1'b0;
        chk(tag, {24'h0, pxl}, {24'h0, exp});
    endtask

    task automatic load(input logic [15:0] d, input logic [2:0] p, input logic pr, input logic hf);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_pal   = p;
        ld_prio  = pr;
        ld_hflip = hf;
    endtask

    initial begin
        rst_n = 1'b0; pxl_cen = 1'b0; line_start = 1'b0; active = 1'b0;
        ld_valid = 1'b0; ld_data = 16'h0; ld_pal = 3'd0; ld_prio = 1'b0;
        ld_hflip = 1'b0; clr_err = 1'b0;

        // Reset state
        #12;
        chk("rst_ready", {31'h0, ld_ready}, 32'h0);
        chk("rst_pxl", {24'h0, pxl}, 32'h0);
        chk("rst_underrun", {31'h0, underrun}, 32'h0);
        chk("rst_cnt", {24'h0, underrun_cnt}, 32'h0);
        #1 rst_n = 1'b1;
        step();
        chk("ready_after_rst", {31'h0, ld_ready}, 32'h1);

        // Single word 0x1234, pal 5, prio 1
        active = 1'b1;
        load(16'h1234, 3'd5, 1'b1, 1'b0);
        step();
        ld_valid = 1'b0;
        step();
        pix("w1_p0", 8'hD1);
        step();
        chk("w1_hold", {24'h0, pxl}, 32'hD1);
        pix("w1_p1", 8'hD2);
        pix("w1_p2", 8'hD3);
        pix("w1_p3", 8'hD4);
        chk("w1_no_underrun", {31'h0, underrun}, 32'h0);

        // Three words with no pixel clock: shifter plus full FIFO
        active = 1'b0;
        load(16'h1234, 3'd2, 1'b0, 1'b0);
        step();
        load(16'h5678, 3'd3, 1'b1, 1'b0);
        step();
        load(16'h0F0F, 3'd1, 1'b0, 1'b0);
        step();
        chk("fill_ready0", {31'h0, ld_ready}, 32'h0);
        ld_valid = 1'b0;
        step();
        chk("fill_ready0_hold", {31'h0, ld_ready}, 32'h0);
        active = 1'b1;
        pix("a_p0", 8'h21);
        pix("a_p1", 8'h22);
        pix("a_p2", 8'h23);
        chk("fill_ready0_3px", {31'h0, ld_ready}, 32'h0);
        pix("a_p3", 8'h24);
        chk("fill_ready1_pop", {31'h0, ld_ready}, 32'h1);
        pix("b_p0", 8'hB5);

        // Refill, advance to index 2, then flush with line_start
        load(16'h9ABC, 3'd7, 1'b0, 1'b0);
        step();
        ld_valid = 1'b0;
        #1;
        chk("refill_ready0", {31'h0, ld_ready}, 32'h0);
        pix("b_p1", 8'hB6);
        active = 1'b0;
        line_start = 1'b1;
        pxl_cen = 1'b1;
        ld_valid = 1'b1;
        #1;
        chk("ls_ready0", {31'h0, ld_ready}, 32'h0);
        step();
        line_start = 1'b0;
        pxl_cen = 1'b0;
        ld_valid = 1'b0;
        chk("ls_pxl0", {24'h0, pxl}, 32'h0);
        chk("ls_no_underrun", {31'h0, underrun}, 32'h0);
        #1;
        chk("ls_ready1", {31'h0, ld_ready}, 32'h1);
        step();

        // Starvation: everything was flushed, so every pixel underruns
        active = 1'b1;
        pxl_cen = 1'b1;
        step();
        chk("starve_pxl0", {24'h0, pxl}, 32'h0);
        chk("starve_flag", {31'h0, underrun}, 32'h1);
        chk("starve_cnt1", {24'h0, underrun_cnt}, 32'h1);
        step();
        chk("starve_cnt2", {24'h0, underrun_cnt}, 32'h2);
        repeat (300) step();
        chk("starve_sat", {24'h0, underrun_cnt}, 32'hFF);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        pxl_cen = 1'b0;
        active = 1'b0;
        chk("clr_cnt", {24'h0, underrun_cnt}, 32'h0);
        chk("clr_flag", {31'h0, underrun}, 32'h0);
        step();
        chk("clr_cnt_hold", {24'h0, underrun_cnt}, 32'h0);

        // Words queued with active low, then resume; first word has hflip set
        load(16'hABCD, 3'd0, 1'b0, 1'b1);
        step();
        load(16'h4321, 3'd4, 1'b0, 1'b0);
        step();
        ld_valid = 1'b0;
        pix("inact_p0", 8'h00);
        pix("inact_p1", 8'h00);
        chk("inact_no_underrun", {31'h0, underrun}, 32'h0);
        active = 1'b1;
`ifdef JTS16_CHAR_HFLIP_EN
        pix("flip_p0", 8'h0D);
        pix("flip_p1", 8'h0C);
        pix("flip_p2", 8'h0B);
        pix("flip_p3", 8'h0A);
`else
        pix("flip_p0", 8'h0A);
        pix("flip_p1", 8'h0B);
        pix("flip_p2", 8'h0C);
        pix("flip_p3", 8'h0D);
`endif
        pix("c_p0", 8'h44);
        pix("c_p1", 8'h43);
        pix("c_p2", 8'h42);
        pix("c_p3", 8'h41);
        active = 1'b0;
        step();
        chk("end_no_underrun", {31'h0, underrun}, 32'h0);
        chk("end_cnt", {24'h0, underrun_cnt}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
